alarm_trigger: RTL

ALARM_TRIGGER -- requirements
Module: alarm_trigger

---
 rtl/alarm_trigger.sv | 107 ++++++++++
 1 files changed

// File: rtl/alarm_trigger.sv
// Car alarm Moore FSM: arm, entry delay, timed siren bursts, hidden-switch disarm.
// State and outputs update one cycle after inputs are sampled; no flow control.
module alarm_trigger #(
    parameter int T_DRIVER    = 6,
    parameter int T_PASSENGER = 10,
    parameter int T_ALARM     = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       armar,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       ignicao,
    input  logic       botao,
    output logic       armed,
    output logic       siren,
    output logic [1:0] status
);

    localparam logic [1:0] S_DISARMED  = 2'd0;
    localparam logic [1:0] S_ARMED     = 2'd1;
    localparam logic [1:0] S_TRIGGERED = 2'd2;
    localparam logic [1:0] S_ALARM     = 2'd3;

    localparam logic [4:0] LD_DRIVER    = 5'(T_DRIVER - 1);
    localparam logic [4:0] LD_PASSENGER = 5'(T_PASSENGER - 1);
    localparam logic [4:0] LD_ALARM     = 5'(T_ALARM - 1);

    logic [1:0] state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       any_door;
    logic       expired;

    assign any_door = door_driver | door_pass;
    assign expired  = (cnt_q == 5'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (botao) begin
            state_d = S_DISARMED;
            cnt_d   = 5'd0;
        end else begin
            case (state_q)
                S_DISARMED: begin
                    cnt_d = 5'd0;
                    if (armar && !any_door && !ignicao) begin
                        state_d = S_ARMED;
                    end
                end
                S_ARMED: begin
                    cnt_d = 5'd0;
                    if (any_door) begin
                        state_d = S_TRIGGERED;
                        // Driver door wins when both open together
                        cnt_d   = door_driver ? LD_DRIVER : LD_PASSENGER;
                    end
                end
                S_TRIGGERED: begin
                    if (ignicao) begin
                        state_d = S_DISARMED;
                        cnt_d   = 5'd0;
                    end else if (expired) begin
                        state_d = S_ALARM;
                        cnt_d   = LD_ALARM;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                S_ALARM: begin
                    if (ignicao) begin
                        state_d = S_DISARMED;
                        cnt_d   = 5'd0;
                    end else if (expired) begin
                        if (any_door) begin
                            cnt_d = LD_ALARM;
                        end else begin
                            state_d = S_ARMED;
                            cnt_d   = 5'd0;
                        end
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                default: begin
                    state_d = S_DISARMED;
                    cnt_d   = 5'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_DISARMED;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign armed  = (state_q != S_DISARMED);
    assign siren  = (state_q == S_ALARM);
    assign status = state_q;

endmodule
